// File: rtl/ec_datapath.sv
// ec_datapath: execution datapath of the 8-bit accumulator processor.
// Holds PC, IR, accumulator A, a unified program/data memory and the add/sub ALU.
// Optional macro DP_OVERFLOW_EN adds a sticky signed-overflow output (ovf).
module ec_datapath #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          IRload,
    input  logic          JMPmux,
    input  logic          PCload,
    input  logic          Meminst,
    input  logic          MenWr,
    input  logic [1:0]    Asel,
    input  logic          Aload,
    input  logic          Sub,
    input  logic          Halt,
    input  logic [DW-1:0] data_in,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_data,
    output logic [2:0]    IR,
`ifdef DP_OVERFLOW_EN
    output logic          ovf,
`endif
    output logic          Aeq0,
    output logic          Apos,
    output logic [DW-1:0] A_out,
    output logic [AW-1:0] PC_out
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] r_mem [0:DEPTH-1];
    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_ir;
    logic [DW-1:0] r_a;

    logic [DW-1:0] w_inst;
    logic [DW-1:0] w_m;
    logic [DW-1:0] w_b;
    logic [DW-1:0] w_alu;
    logic [DW-1:0] w_amux;
    logic [AW-1:0] w_waddr;
    logic          w_run;

    // Reset and Halt both freeze architectural updates; program load is independent of them.
    assign w_run   = !reset && !Halt;

    // Two asynchronous read ports: instruction at PC, operand at the IR address field.
    assign w_inst  = r_mem[r_pc];
    assign w_m     = r_mem[r_ir[AW-1:0]];
    assign w_waddr = Meminst ? r_ir[AW-1:0] : r_pc;

    // Subtract as A + ~M + 1; carry/borrow out is simply dropped.
    assign w_b     = Sub ? ~w_m : w_m;
    assign w_alu   = r_a + w_b + {{(DW-1){1'b0}}, Sub};

    // Accumulator source select.
    always_comb begin
        w_amux = '0;
        case (Asel)
            2'b00:   w_amux = w_alu;
            2'b01:   w_amux = data_in;
            2'b10:   w_amux = w_m;
            default: w_amux = '0;
        endcase
    end

    // Memory write port: program load wins and drops a same-edge datapath store.
    always_ff @(posedge clock) begin
        if (prog_we)
            r_mem[prog_addr] <= prog_data;
        else if (MenWr && w_run)
            r_mem[w_waddr] <= r_a;
    end

    // PC / IR / A registers; every read above uses pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc <= '0;
            r_ir <= '0;
            r_a  <= '0;
        end else if (!Halt) begin
            if (IRload)
                r_ir <= w_inst;
            if (PCload)
                r_pc <= JMPmux ? r_ir[AW-1:0] : r_pc + 1'b1;
            if (Aload)
                r_a  <= w_amux;
        end
    end

`ifdef DP_OVERFLOW_EN
    logic r_ovf;
    logic w_ovf;

    // Signed overflow: addends share a sign and the result sign differs from it.
    assign w_ovf = (r_a[DW-1] == w_b[DW-1]) && (w_alu[DW-1] != r_a[DW-1]);

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset)
            r_ovf <= 1'b0;
        else if (!Halt && Aload && (Asel == 2'b00) && w_ovf)
            r_ovf <= 1'b1;
    end

    assign ovf = r_ovf;
`endif

    assign IR     = r_ir[DW-1:DW-3];
    assign Aeq0   = (r_a == '0);
    assign Apos   = !r_a[DW-1] && (r_a != '0);
    assign A_out  = r_a;
    assign PC_out = r_pc;

endmodule

// File: tb/tb_ec_datapath.sv
// Directed self-checking bench for ec_datapath.
module tb_ec_datapath;

    logic       clock = 1'b0;
    logic       reset, IRload, JMPmux, PCload, Meminst, MenWr, Aload, Sub, Halt, prog_we;
    logic [1:0] Asel;
    logic [7:0] data_in, prog_data;
    logic [4:0] prog_addr;
    logic [2:0] IR;
    logic       Aeq0, Apos;
    logic [7:0] A_out;
    logic [4:0] PC_out;
`ifdef DP_OVERFLOW_EN
    logic       ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    ec_datapath dut (
        .clock(clock), .reset(reset), .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload),
        .Meminst(Meminst), .MenWr(MenWr), .Asel(Asel), .Aload(Aload), .Sub(Sub), .Halt(Halt),
        .data_in(data_in), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .IR(IR),
`ifdef DP_OVERFLOW_EN
        .ovf(ovf),
`endif
        .Aeq0(Aeq0), .Apos(Apos), .A_out(A_out), .PC_out(PC_out)
    );

    task automatic idle();
        reset = 0; IRload = 0; JMPmux = 0; PCload = 0; Meminst = 0; MenWr = 0;
        Asel = 2'b00; Aload = 0; Sub = 0; Halt = 0; data_in = 8'h00;
        prog_we = 0; prog_addr = 5'd0; prog_data = 8'h00;
    endtask

    // One clock edge; outputs are stable 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic prog(input logic [4:0] a, input logic [7:0] d);
        idle();
        prog_we = 1; prog_addr = a; prog_data = d;
        step();
        idle();
    endtask

    task automatic fetch();
        idle(); IRload = 1; PCload = 1;
        step(); idle();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            {IRload, JMPmux, PCload, Meminst, Aload, Sub} = 6'($urandom);
            Asel = 2'($urandom); data_in = 8'($urandom); MenWr = 0; Halt = 0; reset = 0;
            step();
        end
        idle(); reset = 1;
        step(); step();
        idle();
        n_vec++; if (PC_out !== 5'd0) begin n_err++; $display("FAIL reset_pc got %h exp 00", PC_out); end
        n_vec++; if (A_out !== 8'h00) begin n_err++; $display("FAIL reset_a got %h exp 00", A_out); end
        n_vec++; if (IR !== 3'b000)   begin n_err++; $display("FAIL reset_ir got %b exp 000", IR); end
        n_vec++; if (Aeq0 !== 1'b1)   begin n_err++; $display("FAIL reset_aeq0 got %b exp 1", Aeq0); end
        n_vec++; if (Apos !== 1'b0)   begin n_err++; $display("FAIL reset_apos got %b exp 0", Apos); end
    endtask

    task automatic test_load();
        prog(5'd0, 8'h1F); prog(5'd31, 8'h05);
        prog(5'd1, 8'h0A); prog(5'd10, 8'h07);
        prog(5'd2, 8'h0B); prog(5'd11, 8'h02);
        prog(5'd3, 8'hA9); prog(5'd9, 8'h2C);
        fetch();
        n_vec++; if (IR !== 3'b000)  begin n_err++; $display("FAIL fetch_ir got %b exp 000", IR); end
        n_vec++; if (PC_out !== 5'd1) begin n_err++; $display("FAIL fetch_pc got %h exp 01", PC_out); end
        Asel = 2'b10; Aload = 1; step(); idle();
        n_vec++; if (A_out !== 8'h05) begin n_err++; $display("FAIL load_a got %h exp 05", A_out); end
        n_vec++; if (Apos !== 1'b1)   begin n_err++; $display("FAIL load_apos got %b exp 1", Apos); end
    endtask

    task automatic test_alu();
        fetch();  // IR addr 10 -> M = 7
        Asel = 2'b00; Sub = 1; Aload = 1; step(); idle();
        n_vec++; if (A_out !== 8'hFE) begin n_err++; $display("FAIL sub_a got %h exp fe", A_out); end
        n_vec++; if (Apos !== 1'b0)   begin n_err++; $display("FAIL sub_apos got %b exp 0", Apos); end
        n_vec++; if (Aeq0 !== 1'b0)   begin n_err++; $display("FAIL sub_aeq0 got %b exp 0", Aeq0); end
        fetch();  // IR addr 11 -> M = 2
        Asel = 2'b00; Sub = 0; Aload = 1; step(); idle();
        n_vec++; if (A_out !== 8'h00) begin n_err++; $display("FAIL add_a got %h exp 00", A_out); end
        n_vec++; if (Aeq0 !== 1'b1)   begin n_err++; $display("FAIL add_aeq0 got %b exp 1", Aeq0); end
    endtask

    task automatic test_jump();
        fetch();  // IR_reg = A9, PC = 4
        n_vec++; if (IR !== 3'b101)   begin n_err++; $display("FAIL jfetch_ir got %b exp 101", IR); end
        JMPmux = 1; PCload = 1; step(); idle();
        n_vec++; if (PC_out !== 5'd9) begin n_err++; $display("FAIL jump_pc got %h exp 09", PC_out); end
        JMPmux = 1; PCload = 0; step(); idle();
        n_vec++; if (PC_out !== 5'd9) begin n_err++; $display("FAIL jump_hold_pc got %h exp 09", PC_out); end
        // fetch and jump together: jump to old IR addr (9), IR gets mem[9] = 2C
        IRload = 1; PCload = 1; JMPmux = 1; step(); idle();
        n_vec++; if (PC_out !== 5'd9) begin n_err++; $display("FAIL fj_pc got %h exp 09", PC_out); end
        n_vec++; if (IR !== 3'b001)   begin n_err++; $display("FAIL fj_ir got %b exp 001", IR); end
    endtask

    task automatic test_write();
        // IR addr is 12
        data_in = 8'h3C; Asel = 2'b01; Aload = 1; step(); idle();
        n_vec++; if (A_out !== 8'h3C) begin n_err++; $display("FAIL in_a got %h exp 3c", A_out); end
        // store old A while A is cleared on the same edge
        Meminst = 1; MenWr = 1; Asel = 2'b11; Aload = 1; step(); idle();
        n_vec++; if (A_out !== 8'h00) begin n_err++; $display("FAIL clr_a got %h exp 00", A_out); end
        Asel = 2'b10; Aload = 1; step(); idle();
        n_vec++; if (A_out !== 8'h3C) begin n_err++; $display("FAIL store_m12 got %h exp 3c", A_out); end
        // prog_we beats MenWr on the same edge
        Meminst = 1; MenWr = 1; prog_we = 1; prog_addr = 5'd12; prog_data = 8'h77; step(); idle();
        Asel = 2'b10; Aload = 1; step(); idle();
        n_vec++; if (A_out !== 8'h77) begin n_err++; $display("FAIL prio_m12 got %h exp 77", A_out); end
    endtask

    task automatic test_wrap();
        prog(5'd9, 8'h1F);
        fetch();  // PC = 9 -> IR_reg = 1F, PC = 10
        JMPmux = 1; PCload = 1; step(); idle();
        n_vec++; if (PC_out !== 5'd31) begin n_err++; $display("FAIL jump31_pc got %h exp 1f", PC_out); end
        fetch();  // IR_reg = mem[31] = 05
        n_vec++; if (PC_out !== 5'd0)  begin n_err++; $display("FAIL wrap_pc got %h exp 00", PC_out); end
        n_vec++; if (IR !== 3'b000)    begin n_err++; $display("FAIL wrap_ir got %b exp 000", IR); end
    endtask

    task automatic test_halt();
        prog(5'd0, 8'hE3); prog(5'd5, 8'h11);
        // PC = 0, IR_reg = 05, A = 77
        Halt = 1; IRload = 1; PCload = 1; Aload = 1; Asel = 2'b00; MenWr = 1; Meminst = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++;
            if (PC_out !== 5'd0 || IR !== 3'b000 || A_out !== 8'h77) begin
                n_err++;
                $display("FAIL halt_hold cyc %0d got pc=%h ir=%b a=%h exp pc=00 ir=000 a=77", i, PC_out, IR, A_out);
            end
        end
        idle();
        Asel = 2'b10; Aload = 1; step(); idle();
        n_vec++; if (A_out !== 8'h11) begin n_err++; $display("FAIL halt_nowr got %h exp 11", A_out); end
    endtask

    task automatic test_prog_in_reset();
        prog(5'd13, 8'h42);
        reset = 1; prog_we = 1; prog_addr = 5'd0; prog_data = 8'h0D; step(); idle();
        n_vec++; if (PC_out !== 5'd0) begin n_err++; $display("FAIL rst_pc got %h exp 00", PC_out); end
        fetch();  // IR_reg = 0D
        Asel = 2'b10; Aload = 1; step(); idle();
        n_vec++; if (A_out !== 8'h42) begin n_err++; $display("FAIL rst_prog got %h exp 42", A_out); end
    endtask

`ifdef DP_OVERFLOW_EN
    task automatic test_ovf();
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_init got %b exp 0", ovf); end
        prog(5'd13, 8'h01);
        data_in = 8'h7F; Asel = 2'b01; Aload = 1; step(); idle();
        Asel = 2'b00; Sub = 0; Aload = 1; step(); idle();
        n_vec++; if (A_out !== 8'h80) begin n_err++; $display("FAIL ovf_sum got %h exp 80", A_out); end
        n_vec++; if (ovf !== 1'b1)    begin n_err++; $display("FAIL ovf_set got %b exp 1", ovf); end
        Asel = 2'b11; Aload = 1; step(); idle();
        n_vec++; if (ovf !== 1'b1)    begin n_err++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
        reset = 1; step(); idle();
        n_vec++; if (ovf !== 1'b0)    begin n_err++; $display("FAIL ovf_clr got %b exp 0", ovf); end
    endtask
`endif

    initial begin
        idle();
        step();
        test_reset();
        test_load();
        test_alu();
        test_jump();
        test_write();
        test_wrap();
        test_halt();
        test_prog_in_reset();
`ifdef DP_OVERFLOW_EN
        test_ovf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
